// File: rtl/mem_access_unit.sv
// mem_access_unit: load/store unit bridging a pipeline request port to a Wishbone classic master.
module mem_access_unit #(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [2:0]        req_funct3,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic [1:0]        rsp_err,
  output logic              busy,
  output logic              wb_cyc,
  output logic              wb_stb,
  output logic              wb_we,
  output logic [ADDR_W-1:0] wb_adr,
  output logic [DATA_W-1:0] wb_dat_mosi,
  output logic [DATA_W/8-1:0] wb_sel,
  input  logic [DATA_W-1:0] wb_dat_miso,
  input  logic              wb_ack,
  input  logic              wb_err
);
  localparam int NB = DATA_W / 8;
  localparam int OB = $clog2(NB);
  localparam int TW = TIMEOUT > 1 ? $clog2(TIMEOUT + 1) : 1;
  typedef enum logic [1:0] {IDLE, REQUEST, WAIT_ACK, RESP} state_t;
  state_t state, state_nx;
  logic [2:0] f3;
  logic [OB-1:0] off;
  logic [TW-1:0] cnt;
  logic [1:0] sz;
  logic legal, misal, bad, accept, timeout;
  logic [NB-1:0] smask, sel;
  logic [DATA_W-1:0] rep, sh, top, ext;
  int amt;
  assign sz = req_funct3[1:0];
  assign legal = req_funct3 != 3'b111 && (DATA_W == 64 || (sz != 2'd3 && req_funct3 != 3'b110));
  assign misal = (req_addr[OB-1:0] & OB'((1 << sz) - 1)) != '0;
  assign bad = !legal || misal;
  assign accept = req_valid && req_ready;
  assign timeout = TIMEOUT != 0 && int'(cnt) + 1 == TIMEOUT;
  assign smask = NB'((1 << (1 << sz)) - 1);
  assign sel = smask << req_addr[OB-1:0];
  // Store data is replicated so every byte lane of the access size sees it.
  always_comb begin
    rep = '0;
    for (int i = 0; i < NB; i++) rep[8*i +: 8] = req_wdata[8*(i & ((1 << sz) - 1)) +: 8];
  end
  // Load extraction: align the addressed lanes to bit 0, then extend by pushing to the top and back.
  always_comb begin
    sh = wb_dat_miso >> {off, 3'b000};
    amt = DATA_W - (8 << f3[1:0]);
    top = sh << amt;
    ext = f3[2] ? top >> amt : DATA_W'($signed(top) >>> amt);
  end
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:     state_nx = accept ? (bad ? RESP : REQUEST) : IDLE;
      REQUEST:  state_nx = WAIT_ACK;
      WAIT_ACK: state_nx = (wb_ack || wb_err || timeout) ? RESP : WAIT_ACK;
      default:  state_nx = IDLE;
    endcase
    req_ready = state == IDLE;
    busy = state != IDLE;
    wb_cyc = state == REQUEST || state == WAIT_ACK;
    wb_stb = wb_cyc;
    rsp_valid = state == RESP;
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      wb_we <= 1'b0;
      wb_adr <= '0;
      wb_sel <= '0;
      wb_dat_mosi <= '0;
      f3 <= '0;
      off <= '0;
      cnt <= '0;
      rsp_rdata <= '0;
      rsp_err <= 2'b00;
    end else begin
      state <= state_nx;
      cnt <= state == WAIT_ACK ? cnt + 1'b1 : '0;
      if (accept) begin
        wb_we <= req_we;
        wb_adr <= req_addr & ~ADDR_W'(NB - 1);
        wb_sel <= bad ? '0 : sel;
        wb_dat_mosi <= rep;
        f3 <= req_funct3;
        off <= req_addr[OB-1:0];
        if (bad) begin
          rsp_err <= 2'b11;
          rsp_rdata <= '0;
        end
      end
      // Error wins over a simultaneous ack; neither means the timeout fired.
      if (state == WAIT_ACK && state_nx == RESP) begin
        rsp_err <= wb_err ? 2'b01 : wb_ack ? 2'b00 : 2'b10;
        rsp_rdata <= (wb_ack && !wb_err && !wb_we) ? ext : '0;
      end
    end
  end
endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit: randomized scoreboard bench with a bus responder, plus directed 64-bit checks.
module tb_mem_access_unit;
  logic clk = 0, rst = 0;
  always #5 clk = ~clk;
  int tests = 0, fails = 0, cyc_n = 0;
  always @(posedge clk) cyc_n <= cyc_n + 1;
  logic req_valid = 0, req_ready, req_we = 0, rsp_valid, busy;
  logic [2:0] req_funct3 = 0;
  logic [31:0] req_addr = 0, req_wdata = 0, rsp_rdata;
  logic [1:0] rsp_err;
  logic wb_cyc, wb_stb, wb_we, wb_ack, wb_err;
  logic [31:0] wb_adr, wb_dat_mosi, wb_dat_miso;
  logic [3:0] wb_sel;
  mem_access_unit #(.DATA_W(32), .ADDR_W(32), .TIMEOUT(4)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata), .rsp_valid(rsp_valid),
    .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .busy(busy), .wb_cyc(wb_cyc), .wb_stb(wb_stb),
    .wb_we(wb_we), .wb_adr(wb_adr), .wb_dat_mosi(wb_dat_mosi), .wb_sel(wb_sel),
    .wb_dat_miso(wb_dat_miso), .wb_ack(wb_ack), .wb_err(wb_err));
  logic x_req_valid = 0, x_req_ready, x_rsp_valid, x_busy, x_wb_cyc, x_wb_stb, x_wb_we;
  logic x_wb_ack = 0, x_wb_err = 0;
  logic [2:0] x_req_funct3 = 0;
  logic [31:0] x_req_addr = 0, x_wb_adr;
  logic [63:0] x_rsp_rdata, x_wb_dat_mosi, x_wb_dat_miso = 0;
  logic [1:0] x_rsp_err;
  logic [7:0] x_wb_sel;
  mem_access_unit #(.DATA_W(64), .ADDR_W(32)) dut64 (
    .clk(clk), .rst(rst), .req_valid(x_req_valid), .req_ready(x_req_ready), .req_we(1'b0),
    .req_funct3(x_req_funct3), .req_addr(x_req_addr), .req_wdata(64'h0), .rsp_valid(x_rsp_valid),
    .rsp_rdata(x_rsp_rdata), .rsp_err(x_rsp_err), .busy(x_busy), .wb_cyc(x_wb_cyc),
    .wb_stb(x_wb_stb), .wb_we(x_wb_we), .wb_adr(x_wb_adr), .wb_dat_mosi(x_wb_dat_mosi),
    .wb_sel(x_wb_sel), .wb_dat_miso(x_wb_dat_miso), .wb_ack(x_wb_ack), .wb_err(x_wb_err));
  typedef struct { logic [31:0] rdata; logic [1:0] err; int lat; int acc; } exp_t;
  typedef struct { int kind; int d; logic [31:0] miso, adr, mosi; logic [3:0] sel; logic we; } plan_t;
  exp_t exp_q[$];
  plan_t plan_q[$];
  exp_t me;
  plan_t bp;
  function void chk(string name, logic [63:0] act, logic [63:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endfunction
  // kind: 0 ack, 1 err, 2 ack+err, 3 silent (timeout), 4 silent then late ack after reset
  task automatic issue(input logic we, input logic [2:0] f3, input logic [31:0] addr, wdata,
                       input int kind, d, input logic [31:0] miso, input bit no_rsp);
    int size = 1 << f3[1:0];
    bit bad = f3 == 3'b011 || f3 == 3'b110 || f3 == 3'b111 || addr % size != 0;
    logic [31:0] mask, v = 0;
    exp_t e;
    plan_t p;
    if (!bad) begin
      mask = size == 4 ? 32'hFFFF_FFFF : (32'd1 << (8 * size)) - 1;
      v = (miso >> (8 * (addr % 4))) & mask;
      if (!f3[2] && v[8*size-1]) v = v | ~mask;
    end
    e.err = bad ? 2'd3 : (kind == 1 || kind == 2) ? 2'd1 : kind == 0 ? 2'd0 : 2'd2;
    e.rdata = (e.err == 0 && !we) ? v : 32'h0;
    e.lat = bad ? 1 : kind >= 3 ? 6 : 3 + d;
    p.kind = kind; p.d = d; p.miso = miso; p.we = we;
    p.adr = addr & ~32'd3;
    p.sel = 4'(((1 << size) - 1) << (addr % 4));
    for (int j = 0; j < 4; j++) p.mosi[8*j +: 8] = wdata[8*(j % size) +: 8];
    @(negedge clk);
    for (int w = 0; w < 50 && !req_ready; w++) @(negedge clk);
    if (!req_ready) begin
      chk("ready_wait", 0, 1);
      return;
    end
    req_valid = 1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wdata;
    @(posedge clk);
    #1;
    e.acc = cyc_n;
    if (!no_rsp) exp_q.push_back(e);
    if (!bad) plan_q.push_back(p);
    // Junk request while busy must be ignored.
    req_we = 1'($urandom); req_funct3 = 3'($urandom); req_addr = $urandom; req_wdata = $urandom;
    @(posedge clk);
    #1 req_valid = 0;
  endtask
  task automatic run64(input logic [2:0] f3, input logic [31:0] addr, input logic [63:0] miso,
                       input logic [7:0] sel, input logic [63:0] rd);
    @(negedge clk);
    x_req_valid = 1; x_req_funct3 = f3; x_req_addr = addr;
    @(posedge clk);
    #1 x_req_valid = 0;
    for (int w = 0; w < 10 && !x_wb_cyc; w++) @(negedge clk);
    chk("x_cyc", x_wb_cyc, 1);
    chk("x_sel", x_wb_sel, sel);
    chk("x_adr", x_wb_adr, addr & ~32'd7);
    x_wb_ack = 1; x_wb_dat_miso = miso;
    for (int w = 0; w < 10 && !x_rsp_valid; w++) @(negedge clk);
    chk("x_rsp_valid", x_rsp_valid, 1);
    chk("x_rdata", x_rsp_rdata, rd);
    chk("x_err", x_rsp_err, 0);
    x_wb_ack = 0;
  endtask
  always @(negedge clk) if (rsp_valid) begin
    if (exp_q.size() == 0) chk("unexpected_rsp", 1, 0);
    else begin
      me = exp_q.pop_front();
      chk("rsp_err", rsp_err, me.err);
      chk("rsp_rdata", rsp_rdata, me.rdata);
      chk("latency", cyc_n - me.acc + 1, me.lat);
    end
  end
  initial begin
    wb_ack = 0; wb_err = 0; wb_dat_miso = 0;
    forever begin
      @(negedge clk);
      if (wb_cyc && wb_stb) begin
        chk("bus_expected", plan_q.size() != 0, 1);
        bp.kind = 3;
        if (plan_q.size() != 0) begin
          bp = plan_q.pop_front();
          chk("wb_adr", wb_adr, bp.adr);
          chk("wb_sel", wb_sel, bp.sel);
          chk("wb_we", wb_we, bp.we);
          if (bp.we) chk("wb_dat_mosi", wb_dat_mosi, bp.mosi);
        end
        if (bp.kind < 3) begin
          @(posedge clk);
          repeat (bp.d) @(posedge clk);
          #1;
          wb_ack = bp.kind != 1; wb_err = bp.kind != 0; wb_dat_miso = bp.miso;
          @(posedge clk);
          #1 wb_ack = 0; wb_err = 0; wb_dat_miso = $urandom;
        end
        for (int i = 0; i < 20 && wb_cyc; i++) @(negedge clk);
        chk("cyc_drop", wb_cyc, 0);
        if (bp.kind == 4) begin
          wb_ack = 1; wb_dat_miso = $urandom;
          repeat (2) @(posedge clk);
          #1 wb_ack = 0;
        end
      end
    end
  end
  initial begin
    logic [2:0] f3;
    logic [31:0] addr;
    int k;
    #12;
    chk("rst_cyc", wb_cyc, 0);
    chk("rst_ready", req_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_sel", wb_sel, 0);
    @(negedge clk) rst = 1;
    issue(0, 3'b000, 32'h1003, 32'h0, 0, 0, 32'h80FF_FF12, 0);
    issue(1, 3'b001, 32'h2002, 32'h0000_BEEF, 0, 0, $urandom, 0);
    issue(0, 3'b010, 32'h0001, 32'h0, 0, 0, $urandom, 0);
    issue(0, 3'b010, 32'h0040, 32'h0, 3, 0, $urandom, 0);
    issue(0, 3'b010, 32'h0044, 32'h0, 2, 1, $urandom, 0);
    issue(0, 3'b101, 32'h0046, 32'h0, 0, 2, 32'h8001_0000, 0);
    issue(0, 3'b011, 32'h0048, 32'h0, 0, 0, $urandom, 0);
    issue(1, 3'b000, 32'h004B, 32'h1234_56A5, 1, 0, $urandom, 0);
    // Reset during WAIT_ACK: cycle must drop at once and no response may follow.
    issue(0, 3'b010, 32'h0080, 32'h0, 4, 0, $urandom, 1);
    @(posedge clk);
    #2 rst = 0;
    #1;
    chk("mid_rst_cyc", wb_cyc, 0);
    chk("mid_rst_stb", wb_stb, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_sel", wb_sel, 0);
    chk("mid_rst_adr", wb_adr, 0);
    chk("mid_rst_mosi", wb_dat_mosi, 0);
    chk("mid_rst_rdata", rsp_rdata, 0);
    chk("mid_rst_err", rsp_err, 0);
    @(negedge clk) rst = 1;
    repeat (5) @(posedge clk);
    #1 chk("post_rst_ready", req_ready, 1);
    for (int n = 0; n < 250; n++) begin
      f3 = ($urandom % 5 == 0) ? 3'($urandom) : {1'($urandom), 2'($urandom_range(0, 2))};
      addr = $urandom;
      if ($urandom % 4 != 0) addr = addr & ~((32'd1 << f3[1:0]) - 1);
      k = $urandom % 10;
      issue(1'($urandom), f3, addr, $urandom, k < 6 ? 0 : k < 8 ? 1 : k < 9 ? 2 : 3,
            $urandom_range(0, 2), $urandom, 0);
    end
    for (int w = 0; w < 200 && exp_q.size() != 0; w++) @(negedge clk);
    chk("drain_rsp", exp_q.size(), 0);
    chk("drain_bus", plan_q.size(), 0);
    run64(3'b110, 32'h0C, 64'h8000_0001_0000_0000, 8'hF0, 64'h0000_0000_8000_0001);
    run64(3'b010, 32'h0C, 64'h8000_0001_0000_0000, 8'hF0, 64'hFFFF_FFFF_8000_0001);
    run64(3'b011, 32'h08, 64'h8123_4567_89AB_CDEF, 8'hFF, 64'h8123_4567_89AB_CDEF);
    run64(3'b100, 32'h05, 64'h0000_AB00_0000_0000, 8'h20, 64'h0000_0000_0000_00AB);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/mem_access_unit.md
MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 SHALL have parameter DATA_W, default 32, meaning data/bus width; legal values 32 and 64 only.
REQ-002 SHALL have parameter ADDR_W, default 32, meaning byte-address width.
REQ-003 SHALL have parameter TIMEOUT, default 255, meaning maximum WAIT_ACK cycles before abort; 0 disables the timeout.
REQ-004 SHALL have one clock and asynchronous active-low reset: clk  in  1  rising-edge clock.
REQ-005 rst  in  1  asynchronous, active-low reset.
REQ-006 req_valid  in  1  access request.
REQ-007 req_ready  out  1  unit can accept a request.
REQ-008 req_we  in  1  1=store, 0=load.
REQ-009 req_funct3  in  3  RISC-V size/sign code: 000 B, 001 H, 010 W, 011 D (DATA_W=64 only), 100 BU, 101 HU, 110 WU (DATA_W=64 only).
REQ-010 req_addr  in  ADDR_W  byte address.
REQ-011 req_wdata  in  DATA_W  store data, right-aligned.
REQ-012 rsp_valid  out  1  one-cycle response pulse.
REQ-013 rsp_rdata  out  DATA_W  load result, extended; 0 for stores and errors.
REQ-014 rsp_err  out  2  00 ok, 01 bus error, 10 timeout, 11 misaligned/illegal size.
REQ-015 busy  out  1  stall request to the pipeline.
REQ-016 wb_cyc, wb_stb, wb_we  out  1 each  Wishbone classic master controls.
REQ-017 wb_adr  out  ADDR_W  bus address, aligned down to DATA_W/8 bytes.
REQ-018 wb_dat_mosi  out  DATA_W; wb_sel  out  DATA_W/8; wb_dat_miso  in  DATA_W; wb_ack, wb_err  in  1 each.

Function
REQ-019 SHALL implement FSM states IDLE, REQUEST, WAIT_ACK, RESP.
REQ-020 SHALL assert req_ready only in IDLE; a request is accepted when req_valid && req_ready, and all request fields are latched on that edge.
REQ-021 Accepted access misaligned (addr not a multiple of its size) or with an illegal funct3 SHALL go IDLE->RESP with rsp_err=11 and no bus cycle.
REQ-022 Legal access SHALL go IDLE->REQUEST->WAIT_ACK; wb_cyc=1 in REQUEST and WAIT_ACK; wb_stb=1 in REQUEST and in WAIT_ACK until ack/err (classic pipelined-off handshake).
REQ-023 WAIT_ACK->RESP on wb_ack or wb_err; if both are set, wb_err SHALL take priority.
REQ-024 Timeout counter SHALL clear on entering WAIT_ACK and increment each WAIT_ACK cycle; at count==TIMEOUT it SHALL drop cyc/stb and go to RESP with rsp_err=10.
REQ-025 RESP SHALL last exactly one cycle with rsp_valid=1, then return to IDLE.
REQ-026 wb_sel SHALL be the size mask (1, 3, 15 or 255 bits) shifted left by the low address bits.
REQ-027 wb_dat_mosi SHALL replicate the store data across all lanes of its size.
REQ-028 wb_we SHALL equal the latched req_we.
REQ-029 Load data SHALL be captured from wb_dat_miso on ack, shifted right by 8*low address bits, and masked to size.
REQ-030 Loaded data SHALL be sign-extended for B/H/W(64-bit) and zero-extended for BU/HU/WU.
REQ-031 busy SHALL be 1 in every state except IDLE; best-case load/store latency is accept->rsp_valid = 3 cycles with ack in the first WAIT_ACK cycle.
REQ-032 A request presented while not in IDLE SHALL be ignored.

Reset
REQ-033 On rst low, asynchronously: state=IDLE, wb_cyc=wb_stb=wb_we=0, wb_sel=0, wb_adr=0, wb_dat_mosi=0, rsp_valid=0, rsp_rdata=0, rsp_err=00, busy=0, timeout count=0; req_ready=1 after deassertion.
REQ-034 Reset mid-transaction SHALL drop wb_cyc immediately and produce no response; a late wb_ack SHALL be ignored.

Verification
REQ-035 LB at 0x1003, miso=0x80FF_FF12, ack after 1 cycle -> wb_sel=1000, wb_adr=0x1000, rsp_rdata=0xFFFF_FF80, err=00, 3-cycle latency.
REQ-036 SH at 0x2002, wdata=0x0000_BEEF -> wb_sel=1100, wb_dat_mosi=0xBEEF_BEEF, wb_we=1, rsp_rdata=0.
REQ-037 LW at 0x0001 -> no wb_cyc, rsp_valid next cycle, err=11.
REQ-038 TIMEOUT=4, no ack -> wb_cyc drops after 4 WAIT_ACK cycles, err=10.
REQ-039 ack and err same cycle -> err=01; rst low during WAIT_ACK -> cyc=0 at once, no rsp_valid.
REQ-040 DATA_W=64, LWU at 0x0C, miso upper word 0x8000_0001 -> wb_sel=0xF0, rsp_rdata=0x0000_0000_8000_0001.
